cpu_bus_responder: RTL

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_pkg.sv | 29 ++
 rtl/bus_irq_timer.sv | 74 +++++++
 rtl/cpu_bus_responder.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared address map, CTRL bit positions and timer states for the CPU bus responder.
// Imported by cpu_bus_responder and bus_irq_timer.
package cpu_bus_pkg;

    localparam logic [15:0] RAM_LAST    = 16'h1FFF;
    localparam logic [10:0] RAM_MASK    = 11'h7FF;

    localparam logic [15:0] CTRL_ADDR   = 16'h4100;
    localparam logic [15:0] RLO_ADDR    = 16'h4101;
    localparam logic [15:0] RHI_ADDR    = 16'h4102;
    localparam logic [15:0] STAT_ADDR   = 16'h4103;

    localparam logic [15:0] NMI_LO_ADDR = 16'hFFFA;
    localparam logic [15:0] NMI_HI_ADDR = 16'hFFFB;
    localparam logic [15:0] RST_LO_ADDR = 16'hFFFC;
    localparam logic [15:0] RST_HI_ADDR = 16'hFFFD;
    localparam logic [15:0] IRQ_LO_ADDR = 16'hFFFE;
    localparam logic [15:0] IRQ_HI_ADDR = 16'hFFFF;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_NMI_EN = 1;
    localparam int CTRL_AUTO   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } timer_state_t;

endpackage

// File: rtl/bus_irq_timer.sv
// Down-counting interval timer raising a level IRQ and a stretched NMI pulse.
// Instantiated by cpu_bus_responder only when BUS_IRQ_TIMER_EN is defined.
module bus_irq_timer
    import cpu_bus_pkg::*;
#(
    parameter int unsigned NMI_PULSE = 8
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic        wr_ctrl,
    input  logic        wr_rlo,
    input  logic        wr_rhi,
    input  logic        wr_stat,
    input  logic [7:0]  wdata,
    output logic [2:0]  ctrl,
    output logic [15:0] reload,
    output logic [7:0]  status,
    output logic        irq,
    output logic        nmi
);

    timer_state_t state;
    logic [15:0]  count;
    logic [7:0]   pulse;
    logic         pending;
    logic         expire;
    logic [15:0]  new_reload;

    assign expire     = (state == COUNT) && (count == 16'd1);
    assign new_reload = {wdata, reload[7:0]};

    // Registers, counter FSM, pending flag and NMI stretcher; a $4102 write beats expiry.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state   <= IDLE;
            ctrl    <= 3'd0;
            reload  <= 16'd0;
            count   <= 16'd0;
            pulse   <= 8'd0;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= wdata[2:0];
            if (wr_rlo) reload[7:0] <= wdata;
            if (wr_rhi) begin
                reload[15:8] <= wdata;
                if (new_reload != 16'd0) begin
                    count <= new_reload;
                    state <= COUNT;
                end else begin
                    count <= 16'd0;
                    state <= IDLE;
                end
            end else if (expire) begin
                if (ctrl[CTRL_AUTO] && reload != 16'd0) begin
                    count <= reload;
                end else begin
                    count <= 16'd0;
                    state <= IDLE;
                end
            end else if (state == COUNT) begin
                count <= count - 16'd1;
            end
            if (expire && ctrl[CTRL_IRQ_EN]) pending <= 1'b1;
            else if (wr_stat) pending <= 1'b0;
            if (expire && ctrl[CTRL_NMI_EN]) pulse <= NMI_PULSE[7:0];
            else if (pulse != 8'd0) pulse <= pulse - 8'd1;
        end
    end

    assign status = {6'd0, state == COUNT, pending};
    assign irq    = ~pending;
    assign nmi    = (pulse == 8'd0);

endmodule

// File: rtl/cpu_bus_responder.sv
// Bus slave for a 6502-style CPU: mirrored RAM, vector ROM, optional IRQ/NMI timer.
// Define BUS_IRQ_TIMER_EN to build the timer at $4100-$4103.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [15:0] NMI_VEC   = 16'h0004,
    parameter logic [15:0] IRQ_VEC   = 16'h0000,
    parameter int unsigned NMI_PULSE = 8
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] Addr_bus,
    input  logic [7:0]  Data_bus_out,
    input  logic        R_nW,
    output logic [7:0]  Data_bus_in,
    output logic        irq,
    output logic        nmi
);

    logic [7:0]  ram [0:2047];
    logic        ram_sel;
    logic [10:0] ram_idx;

    assign ram_sel = (Addr_bus <= RAM_LAST);
    assign ram_idx = Addr_bus[10:0] & RAM_MASK;

    // RAM write port; bus writes during reset are not meaningful and are dropped.
    always_ff @(posedge clk_ph1) begin
        if (rst && !R_nW && ram_sel) ram[ram_idx] <= Data_bus_out;
    end

`ifdef BUS_IRQ_TIMER_EN
    logic [2:0]  ctrl;
    logic [15:0] reload;
    logic [7:0]  status;
    logic        wr;

    assign wr = ~R_nW;

    bus_irq_timer #(
        .NMI_PULSE (NMI_PULSE)
    ) u_timer (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .wr_ctrl (wr && Addr_bus == CTRL_ADDR),
        .wr_rlo  (wr && Addr_bus == RLO_ADDR),
        .wr_rhi  (wr && Addr_bus == RHI_ADDR),
        .wr_stat (wr && Addr_bus == STAT_ADDR),
        .wdata   (Data_bus_out),
        .ctrl    (ctrl),
        .reload  (reload),
        .status  (status),
        .irq     (irq),
        .nmi     (nmi)
    );
`else
    assign irq = 1'b1;
    assign nmi = 1'b1;
`endif

    // Combinational read mux, driven whatever R_nW says.
    always_comb begin
        Data_bus_in = 8'h00;
        if (ram_sel) begin
            Data_bus_in = ram[ram_idx];
        end else begin
            case (Addr_bus)
                NMI_LO_ADDR: Data_bus_in = NMI_VEC[7:0];
                NMI_HI_ADDR: Data_bus_in = NMI_VEC[15:8];
                RST_LO_ADDR: Data_bus_in = RESET_VEC[7:0];
                RST_HI_ADDR: Data_bus_in = RESET_VEC[15:8];
                IRQ_LO_ADDR: Data_bus_in = IRQ_VEC[7:0];
                IRQ_HI_ADDR: Data_bus_in = IRQ_VEC[15:8];
`ifdef BUS_IRQ_TIMER_EN
                CTRL_ADDR:   Data_bus_in = {5'd0, ctrl};
                RLO_ADDR:    Data_bus_in = reload[7:0];
                RHI_ADDR:    Data_bus_in = reload[15:8];
                STAT_ADDR:   Data_bus_in = status;
`endif
                default:     Data_bus_in = 8'h00;
            endcase
        end
    end

endmodule
